// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID->EX pipeline register with stall, flush, load-use bubble and bubble counter
module id_ex_pipe_reg #(
    parameter int DATA_W    = 32,
    parameter int NUM_OPS   = 3,
    parameter int CTRL_W    = 8,
    parameter int MEMRD_BIT = 0,
    parameter int REG_W     = 5,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [DATA_W-1:0]         id_pc,
    input  logic [NUM_OPS*DATA_W-1:0] id_ops,
    input  logic [CTRL_W-1:0]         id_ctrl,
    input  logic [REG_W-1:0]          id_rs,
    input  logic [REG_W-1:0]          id_rt,
    input  logic [REG_W-1:0]          id_rd,
    input  logic                      stall_ext,
    input  logic                      flush,
    output logic                      ex_valid,
    output logic [DATA_W-1:0]         ex_pc,
    output logic [NUM_OPS*DATA_W-1:0] ex_ops,
    output logic [CTRL_W-1:0]         ex_ctrl,
    output logic [REG_W-1:0]          ex_rs,
    output logic [REG_W-1:0]          ex_rt,
    output logic [REG_W-1:0]          ex_rd,
    output logic                      hazard_stall,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                      r_valid;
    logic [DATA_W-1:0]         r_pc;
    logic [NUM_OPS*DATA_W-1:0] r_ops;
    logic [CTRL_W-1:0]         r_ctrl;
    logic [REG_W-1:0]          r_rs;
    logic [REG_W-1:0]          r_rt;
    logic [REG_W-1:0]          r_rd;
    logic [CNT_W-1:0]          r_bubble_cnt;

    logic w_ex_is_load;
    logic w_rd_match;
    logic w_hazard_raw;
    logic w_hazard_stall;
    logic w_load;
    logic w_bubble;
    logic w_cnt_sat;

    // A load in EX writing a non-zero register that the ID instruction reads is a load-use hazard.
    assign w_ex_is_load   = r_valid & r_ctrl[MEMRD_BIT];
    assign w_rd_match     = (r_rd != '0) & ((r_rd == id_rs) | (r_rd == id_rt));
    assign w_hazard_raw   = id_valid & w_ex_is_load & w_rd_match;

    // A taken branch kills the ID instruction anyway, so it must not also freeze the front end.
    assign w_hazard_stall = w_hazard_raw & ~flush;

    // Edge actions in priority order: flush, external stall, hazard bubble, normal load.
    assign w_bubble  = flush | (~stall_ext & w_hazard_stall);
    assign w_load    = ~flush & ~stall_ext & ~w_hazard_stall;
    assign w_cnt_sat = (r_bubble_cnt == CNT_MAX);

    // Valid and control: loaded on a normal advance, cleared together on any bubble so no stale
    // control ever sits behind an invalid slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_load) begin
            r_valid <= id_valid;
            r_ctrl  <= id_valid ? id_ctrl : '0;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end

    // Data and specifier payload: only a normal advance replaces it; bubbles and stalls keep it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= '0;
            r_ops <= '0;
            r_rs  <= '0;
            r_rt  <= '0;
            r_rd  <= '0;
        end else if (w_load) begin
            r_pc  <= id_pc;
            r_ops <= id_ops;
            r_rs  <= id_rs;
            r_rt  <= id_rt;
            r_rd  <= id_rd;
        end
    end

    // Count every inserted bubble (hazard or flush), sticking at the top value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && !w_cnt_sat) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_ops       = r_ops;
    assign ex_ctrl      = r_ctrl;
    assign ex_rs        = r_rs;
    assign ex_rt        = r_rt;
    assign ex_rd        = r_rd;
    assign hazard_stall = w_hazard_stall;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    localparam int DW = 32;
    localparam int NO = 3;
    localparam int CW = 8;
    localparam int RW = 5;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [DW-1:0]   id_pc;
    logic [NO*DW-1:0] id_ops;
    logic [CW-1:0]   id_ctrl;
    logic [RW-1:0]   id_rs, id_rt, id_rd;
    logic            stall_ext, flush;

    logic            ex_valid, hazard_stall;
    logic [DW-1:0]   ex_pc;
    logic [NO*DW-1:0] ex_ops;
    logic [CW-1:0]   ex_ctrl;
    logic [RW-1:0]   ex_rs, ex_rt, ex_rd;
    logic [15:0]     bubble_cnt;

    logic            ex_valid2, hazard_stall2;
    logic [DW-1:0]   ex_pc2;
    logic [NO*DW-1:0] ex_ops2;
    logic [CW-1:0]   ex_ctrl2;
    logic [RW-1:0]   ex_rs2, ex_rt2, ex_rd2;
    logic [1:0]      bubble_cnt2;

    int tests_run = 0;
    int tests_failed = 0;

    // reference state
    bit              m_valid;
    logic [DW-1:0]   m_pc;
    logic [NO*DW-1:0] m_ops;
    logic [CW-1:0]   m_ctrl;
    logic [RW-1:0]   m_rs, m_rt, m_rd;
    int              m_cnt, m_cnt2;

    id_ex_pipe_reg #(.DATA_W(DW), .NUM_OPS(NO), .CTRL_W(CW), .MEMRD_BIT(0), .REG_W(RW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_ops(id_ops),
        .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .stall_ext(stall_ext), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ops(ex_ops), .ex_ctrl(ex_ctrl),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.DATA_W(DW), .NUM_OPS(NO), .CTRL_W(CW), .MEMRD_BIT(0), .REG_W(RW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_ops(id_ops),
        .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .stall_ext(stall_ext), .flush(flush),
        .ex_valid(ex_valid2), .ex_pc(ex_pc2), .ex_ops(ex_ops2), .ex_ctrl(ex_ctrl2),
        .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2),
        .hazard_stall(hazard_stall2), .bubble_cnt(bubble_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // load-use rule: EX holds a valid load to a non-zero reg that ID reads, and no branch squash
    function automatic bit model_hazard();
        bit reads;
        reads = (m_rd == id_rs) || (m_rd == id_rt);
        return id_valid && m_valid && m_ctrl[0] && (m_rd != 0) && reads && !flush;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = '0; m_ops = '0; m_ctrl = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge(input bit hz);
        if (flush || (!stall_ext && hz)) begin
            m_valid = 0;
            m_ctrl  = '0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else if (!stall_ext) begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? id_ctrl : '0;
            m_pc = id_pc; m_ops = id_ops;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ex_valid"}, ex_valid, m_valid);
        chk({tag, ".ex_pc"}, ex_pc, m_pc);
        chk({tag, ".ex_ops"}, ex_ops, m_ops);
        chk({tag, ".ex_ctrl"}, ex_ctrl, m_ctrl);
        chk({tag, ".ex_rs"}, ex_rs, m_rs);
        chk({tag, ".ex_rt"}, ex_rt, m_rt);
        chk({tag, ".ex_rd"}, ex_rd, m_rd);
        chk({tag, ".bubble_cnt"}, bubble_cnt, m_cnt);
        chk({tag, ".ex_valid2"}, ex_valid2, m_valid);
        chk({tag, ".ex_fields2"}, {ex_pc2, ex_ops2, ex_ctrl2}, {m_pc, m_ops, m_ctrl});
        chk({tag, ".ex_spec2"}, {ex_rs2, ex_rt2, ex_rd2}, {m_rs, m_rt, m_rd});
        chk({tag, ".bubble_cnt2"}, bubble_cnt2, m_cnt2);
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] pc, input logic [NO*DW-1:0] ops,
                         input logic [CW-1:0] ctrl, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] rd, input bit st, input bit fl);
        id_valid = v; id_pc = pc; id_ops = ops; id_ctrl = ctrl;
        id_rs = rs; id_rt = rt; id_rd = rd; stall_ext = st; flush = fl;
    endtask

    // called at posedge+1: settle, check hazard, clock, check registered outputs
    task automatic cycle(input string tag);
        bit hz;
        #1;
        hz = model_hazard();
        chk({tag, ".hazard"}, hazard_stall, hz);
        chk({tag, ".hazard2"}, hazard_stall2, hz);
        @(posedge clk);
        model_edge(hz);
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [NO*DW-1:0] ops_t2;
        rst = 1'b1;
        drive(0, '0, '0, '0, '0, '0, '0, 0, 0);
        model_reset();
        #2;
        check_regs("reset_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T2 pass-through
        ops_t2 = {32'h33, 32'h22, 32'h11};
        drive(1, 32'h104, ops_t2, 8'h06, 5'd1, 5'd2, 5'd3, 0, 0);
        cycle("t2");
        chk("t2.pc_const", ex_pc, 32'h104);
        chk("t2.op0_const", ex_ops[31:0], 32'h11);
        chk("t2.valid_const", ex_valid, 1'b1);

        // T3 load-use: load to r8, then consumer reading r8
        drive(1, 32'h108, {32'h1, 32'h2, 32'h3}, 8'h01, 5'd4, 5'd5, 5'd8, 0, 0);
        cycle("t3_load");
        drive(1, 32'h10c, {32'h4, 32'h5, 32'h6}, 8'h06, 5'd8, 5'd6, 5'd9, 0, 0);
        #1;
        chk("t3.hazard_const", hazard_stall, 1'b1);
        cycle("t3_bubble");
        chk("t3.valid0", ex_valid, 1'b0);
        chk("t3.cnt1", bubble_cnt, 16'd1);
        cycle("t3_release");
        chk("t3.loaded_pc", ex_pc, 32'h10c);

        // T4 reg 0 with mem-read, and r8 without mem-read
        drive(1, 32'h110, {3{32'h7}}, 8'h01, 5'd1, 5'd1, 5'd0, 0, 0);
        cycle("t4_ld_r0");
        drive(1, 32'h114, {3{32'h8}}, 8'h06, 5'd0, 5'd0, 5'd8, 0, 0);
        cycle("t4_use_r0");
        drive(1, 32'h118, {3{32'h9}}, 8'h06, 5'd8, 5'd8, 5'd2, 0, 0);
        cycle("t4_use_r8_noload");
        chk("t4.cnt_const", bubble_cnt, 16'd1);

        // T5 external stall for 3 cycles with a pending hazard
        drive(1, 32'h11c, {3{32'ha}}, 8'h01, 5'd3, 5'd3, 5'd8, 0, 0);
        cycle("t5_load");
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h200 + i, {3{$urandom}}, 8'hf0, 5'd8, 5'(i), 5'd7, 1, 0);
            cycle("t5_stall");
        end
        chk("t5.pc_frozen", ex_pc, 32'h11c);
        chk("t5.cnt_const", bubble_cnt, 16'd1);

        // T6 flush+stall together, then saturate the 2-bit counter
        drive(1, 32'h300, {3{32'hb}}, 8'h06, 5'd1, 5'd2, 5'd3, 1, 1);
        cycle("t6_flush_stall");
        chk("t6.valid0", ex_valid, 1'b0);
        chk("t6.cnt2", bubble_cnt, 16'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h304, {3{32'hc}}, 8'h06, 5'd1, 5'd2, 5'd3, 0, 1);
            cycle("t6_flush");
        end
        chk("t6.sat3", bubble_cnt2, 2'd3);
        chk("t6.cnt_wide", bubble_cnt, 16'd5);

        // T1 async reset mid-stall, no clock edge
        drive(1, 32'h400, {3{32'hd}}, 8'h07, 5'd1, 5'd2, 5'd3, 0, 0);
        cycle("t1_pre");
        stall_ext = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("t1_async");
        @(posedge clk);
        #1;
        check_regs("t1_held");
        rst = 1'b0;
        stall_ext = 1'b0;
        cycle("t1_after");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom, $urandom},
                  8'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
